// File: rtl/cpu_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM states, writeback-select encoding and
// register address width used by the hazard unit.
package cpu_ctrl_pkg;
    localparam int REG_ADDR_W = 5;
    localparam logic [1:0] MEM_TO_REG_LOAD = 2'b01;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;
endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use detector: flags an ID source that depends on a load
// still in EX. Writes to x0 never create a dependency.
module load_use_detect
    import cpu_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_reg_write,
    input  logic [1:0]            ex_mem_to_reg,
    input  logic [REG_ADDR_W-1:0] ex_reg_write_addr,
    output logic                  hazard
);
    logic ex_is_load;
    logic rs1_hit;
    logic rs2_hit;

    assign ex_is_load = ex_reg_write && (ex_mem_to_reg == MEM_TO_REG_LOAD)
                        && (ex_reg_write_addr != '0);
    assign rs1_hit    = id_uses_rs1 && (id_rs1_addr == ex_reg_write_addr);
    assign rs2_hit    = id_uses_rs2 && (id_rs2_addr == ex_reg_write_addr);
    assign hazard     = ex_is_load && (rs1_hit || rs2_hit);
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls with timeout, redirect flushes
// and load-use bubbles, plus saturating stall/flush performance counters.
module hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_reg_write,
    input  logic [1:0]            ex_mem_to_reg,
    input  logic [REG_ADDR_W-1:0] ex_reg_write_addr,
    input  logic                  mem_redirect,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  id_ex_stall,
    output logic                  ex_mem_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic                  mem_wb_flush,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [15:0]           flush_events
);
    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    state_e           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [15:0]      flush_cnt_q;
    logic             lu_q;
    logic             lu_hazard;
    logic             mem_stall;
    logic             redirect;
    logic             lu_stall;
    logic             active;

    load_use_detect u_lud (
        .id_rs1_addr       (id_rs1_addr),
        .id_rs2_addr       (id_rs2_addr),
        .id_uses_rs1       (id_uses_rs1),
        .id_uses_rs2       (id_uses_rs2),
        .ex_reg_write      (ex_reg_write),
        .ex_mem_to_reg     (ex_mem_to_reg),
        .ex_reg_write_addr (ex_reg_write_addr),
        .hazard            (lu_hazard)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        mem_stall  = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    mem_stall  = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == TIMEOUT_C) begin
                    // Abort the access: release the pipeline and flag the error.
                    timeout_d  = 1'b1;
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else begin
                    mem_stall  = 1'b1;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // lu_q blocks a repeat bubble: the cycle after a load-use stall EX holds a bubble.
    assign active   = !rst;
    assign redirect = mem_redirect && !mem_stall;
    assign lu_stall = lu_hazard && (state_q == RUN) && !redirect && !mem_stall && !lu_q;

    assign pc_stall     = active && (mem_stall || lu_stall);
    assign if_id_stall  = active && (mem_stall || lu_stall);
    assign id_ex_stall  = active && mem_stall;
    assign ex_mem_stall = active && mem_stall;
    assign if_id_flush  = active && redirect;
    assign id_ex_flush  = active && (redirect || lu_stall);
    assign ex_mem_flush = active && redirect;
    assign mem_wb_flush = active && mem_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= 8'd0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= 16'd0;
            lu_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
            lu_q       <= lu_stall;
            if (pc_stall) stall_cnt_q <= sat_inc_cnt(stall_cnt_q);
            if (redirect) flush_cnt_q <= sat_inc16(flush_cnt_q);
        end
    end

    assign mem_timeout  = timeout_q;
    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: load-use, x0, memory wait, timeout,
// redirect priority, counter saturation and asynchronous reset.
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1_addr, id_rs2_addr, ex_reg_write_addr;
    logic        id_uses_rs1, id_uses_rs2, ex_reg_write;
    logic [1:0]  ex_mem_to_reg;
    logic        mem_redirect, mem_req, mem_ready;

    logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic        mem_timeout;
    logic [31:0] stall_cycles;
    logic [15:0] flush_events;

    logic        s_pc_stall, s_if_id_stall, s_id_ex_stall, s_ex_mem_stall;
    logic        s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_mem_wb_flush;
    logic        s_mem_timeout;
    logic [1:0]  s_stall_cycles;
    logic [15:0] s_flush_events;

    wire [7:0] ctl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                      if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

    localparam logic [7:0] NONE_C  = 8'b0000_0000;
    localparam logic [7:0] MEMST_C = 8'b1111_0001;
    localparam logic [7:0] REDIR_C = 8'b0000_1110;
    localparam logic [7:0] LU_C    = 8'b1100_0100;

    int vectors = 0;
    int miscompares = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_reg_write_addr(ex_reg_write_addr),
        .mem_redirect(mem_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles),
        .flush_events(flush_events)
    );

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_reg_write_addr(ex_reg_write_addr),
        .mem_redirect(mem_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(s_pc_stall), .if_id_stall(s_if_id_stall),
        .id_ex_stall(s_id_ex_stall), .ex_mem_stall(s_ex_mem_stall),
        .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
        .ex_mem_flush(s_ex_mem_flush), .mem_wb_flush(s_mem_wb_flush),
        .mem_timeout(s_mem_timeout), .stall_cycles(s_stall_cycles),
        .flush_events(s_flush_events)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_reg_write_addr = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_reg_write = 1'b0;
        ex_mem_to_reg = 2'b00; mem_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [1:0] m2r);
        ex_reg_write = 1'b1; ex_mem_to_reg = m2r; ex_reg_write_addr = rd;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_load(5'd5, 2'b01);
        id_rs1_addr = 5'd5; id_uses_rs1 = 1'b1;
        mem_req = 1'b1; mem_ready = 1'b0; mem_redirect = 1'b1;
        @(negedge clk);
        vectors++;
        if (ctl !== NONE_C) begin miscompares++; $display("FAIL reset_ctl got=%b exp=%b", ctl, NONE_C); end
        tick;
        @(negedge clk);
        vectors++;
        if (ctl !== NONE_C || mem_timeout !== 1'b0 || stall_cycles !== 32'd0 || flush_events !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_state got ctl=%b to=%b sc=%0d fe=%0d exp all 0", ctl, mem_timeout, stall_cycles, flush_events);
        end
        idle;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_load_use;
        // lw x5 in EX, add reading x5 in ID
        set_load(5'd5, 2'b01); id_rs1_addr = 5'd5; id_uses_rs1 = 1'b1;
        @(negedge clk);
        vectors++;
        if (ctl !== LU_C) begin miscompares++; $display("FAIL lu_rs1 got=%b exp=%b", ctl, LU_C); end
        tick; exp_stall += 1;
        idle;
        @(negedge clk);
        vectors++;
        if (ctl !== NONE_C) begin miscompares++; $display("FAIL lu_after got=%b exp=%b", ctl, NONE_C); end
        vectors++;
        if (stall_cycles !== 32'd1) begin miscompares++; $display("FAIL lu_count got=%0d exp=1", stall_cycles); end
        tick;
        // rs2 match
        set_load(5'd9, 2'b01); id_rs2_addr = 5'd9; id_uses_rs2 = 1'b1; id_rs1_addr = 5'd3; id_uses_rs1 = 1'b1;
        @(negedge clk);
        vectors++;
        if (ctl !== LU_C) begin miscompares++; $display("FAIL lu_rs2 got=%b exp=%b", ctl, LU_C); end
        tick; exp_stall += 1;
        idle; tick;
        // rs1 and rs2 both match, inputs held for two cycles: one stall only
        set_load(5'd7, 2'b01);
        id_rs1_addr = 5'd7; id_rs2_addr = 5'd7; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
        @(negedge clk);
        vectors++;
        if (ctl !== LU_C) begin miscompares++; $display("FAIL lu_both got=%b exp=%b", ctl, LU_C); end
        tick; exp_stall += 1;
        @(negedge clk);
        vectors++;
        if (ctl !== NONE_C) begin miscompares++; $display("FAIL lu_both_once got=%b exp=%b", ctl, NONE_C); end
        tick;
        idle; tick;
        // non-load writer and unused source must not stall
        set_load(5'd5, 2'b00); id_rs1_addr = 5'd5; id_uses_rs1 = 1'b1;
        @(negedge clk);
        vectors++;
        if (ctl !== NONE_C) begin miscompares++; $display("FAIL lu_nonload got=%b exp=%b", ctl, NONE_C); end
        tick;
        set_load(5'd5, 2'b01); id_uses_rs1 = 1'b0;
        @(negedge clk);
        vectors++;
        if (ctl !== NONE_C) begin miscompares++; $display("FAIL lu_unused got=%b exp=%b", ctl, NONE_C); end
        tick;
        idle; tick;
        vectors++;
        if (stall_cycles !== 32'(exp_stall)) begin miscompares++; $display("FAIL lu_total got=%0d exp=%0d", stall_cycles, exp_stall); end
    endtask

    task automatic test_x0;
        set_load(5'd0, 2'b01);
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
        @(negedge clk);
        vectors++;
        if (ctl !== NONE_C) begin miscompares++; $display("FAIL x0 got=%b exp=%b", ctl, NONE_C); end
        tick;
        idle; tick;
    endtask

    task automatic test_mem_wait;
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (ctl !== MEMST_C) begin miscompares++; $display("FAIL memwait_c%0d got=%b exp=%b", c, ctl, MEMST_C); end
            tick;
        end
        exp_stall += 3;
        mem_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (ctl !== NONE_C) begin miscompares++; $display("FAIL memwait_release got=%b exp=%b", ctl, NONE_C); end
        tick;
        idle;
        @(negedge clk);
        vectors++;
        if (ctl !== NONE_C || stall_cycles !== 32'(exp_stall)) begin
            miscompares++;
            $display("FAIL memwait_after got ctl=%b sc=%0d exp ctl=%b sc=%0d", ctl, stall_cycles, NONE_C, exp_stall);
        end
        tick;
        // zero-wait access in RUN
        mem_req = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (ctl !== NONE_C) begin miscompares++; $display("FAIL zero_wait got=%b exp=%b", ctl, NONE_C); end
        tick;
        idle; tick;
    endtask

    task automatic test_redirect_in_wait;
        mem_req = 1'b1; mem_ready = 1'b0; mem_redirect = 1'b1;
        @(negedge clk);
        vectors++;
        if (ctl !== MEMST_C) begin miscompares++; $display("FAIL redir_wait_hold got=%b exp=%b", ctl, MEMST_C); end
        tick; exp_stall += 1;
        mem_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (ctl !== REDIR_C) begin miscompares++; $display("FAIL redir_wait_release got=%b exp=%b", ctl, REDIR_C); end
        tick; exp_flush += 1;
        idle;
        vectors++;
        if (flush_events !== 16'(exp_flush)) begin miscompares++; $display("FAIL redir_wait_count got=%0d exp=%0d", flush_events, exp_flush); end
        tick;
    endtask

    task automatic test_redirect;
        mem_redirect = 1'b1;
        set_load(5'd5, 2'b01); id_rs1_addr = 5'd5; id_uses_rs1 = 1'b1;
        @(negedge clk);
        vectors++;
        if (ctl !== REDIR_C) begin miscompares++; $display("FAIL redir_lu got=%b exp=%b", ctl, REDIR_C); end
        tick; exp_flush += 1;
        idle;
        vectors++;
        if (flush_events !== 16'(exp_flush) || stall_cycles !== 32'(exp_stall)) begin
            miscompares++;
            $display("FAIL redir_counts got fe=%0d sc=%0d exp fe=%0d sc=%0d", flush_events, stall_cycles, exp_flush, exp_stall);
        end
        tick;
    endtask

    task automatic test_timeout;
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if (ctl !== MEMST_C || mem_timeout !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout_wait_c%0d got ctl=%b to=%b exp ctl=%b to=0", c, ctl, mem_timeout, MEMST_C);
            end
            tick;
        end
        exp_stall += 4;
        @(negedge clk);
        vectors++;
        if (ctl !== NONE_C) begin miscompares++; $display("FAIL timeout_release got=%b exp=%b", ctl, NONE_C); end
        tick;
        idle;
        vectors++;
        if (mem_timeout !== 1'b1) begin miscompares++; $display("FAIL timeout_set got=%b exp=1", mem_timeout); end
        for (int c = 0; c < 3; c++) tick;
        vectors++;
        if (mem_timeout !== 1'b1 || ctl !== NONE_C) begin
            miscompares++;
            $display("FAIL timeout_sticky got to=%b ctl=%b exp to=1 ctl=%b", mem_timeout, ctl, NONE_C);
        end
        vectors++;
        if (stall_cycles !== 32'(exp_stall)) begin miscompares++; $display("FAIL timeout_count got=%0d exp=%0d", stall_cycles, exp_stall); end
    endtask

    task automatic test_saturation;
        vectors++;
        if (s_stall_cycles !== 2'b11) begin miscompares++; $display("FAIL sat_stall got=%0d exp=3", s_stall_cycles); end
    endtask

    task automatic test_async_reset;
        mem_req = 1'b1; mem_ready = 1'b0;
        tick;
        @(negedge clk);
        vectors++;
        if (ctl !== MEMST_C) begin miscompares++; $display("FAIL areset_pre got=%b exp=%b", ctl, MEMST_C); end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (ctl !== NONE_C || mem_timeout !== 1'b0 || stall_cycles !== 32'd0 || flush_events !== 16'd0) begin
            miscompares++;
            $display("FAIL areset_now got ctl=%b to=%b sc=%0d fe=%0d exp all 0", ctl, mem_timeout, stall_cycles, flush_events);
        end
        idle;
        tick;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (ctl !== NONE_C) begin miscompares++; $display("FAIL areset_run got=%b exp=%b", ctl, NONE_C); end
        tick;
        // a fresh wait must stall its full count again
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int c = 0; c < 4; c++) tick;
        @(negedge clk);
        vectors++;
        if (ctl !== NONE_C || stall_cycles !== 32'd4) begin
            miscompares++;
            $display("FAIL areset_restart got ctl=%b sc=%0d exp ctl=%b sc=4", ctl, stall_cycles, NONE_C);
        end
        tick;
        idle; tick;
    endtask

    initial begin
        rst = 1'b1;
        idle;
        test_reset;
        test_load_use;
        test_x0;
        test_mem_wait;
        test_redirect_in_wait;
        test_redirect;
        test_timeout;
        test_saturation;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
